input_stream_fetcher: RTL and testbench

Synthesizable front end of the ECE564 compute datapath. It is the responder side of the dut_run/dut_busy handshake and the reader of the input SRAM. On a run request it fetches a length header and then N data words from the input SRAM, whose read latency is one cycle. It presents those words to the downstream compute core on a valid/ready stream with backpressure, then releases busy.

---
 rtl/ece564_pkg.sv | 19 +
 rtl/skid_fifo2.sv | 48 ++++
 rtl/input_stream_fetcher.sv | 113 +++++++++++
 tb/tb_input_stream_fetcher.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ece564_pkg.sv
// Shared types and sizing helpers for the ECE564 input fetch front end.
package ece564_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        STREAM,
        DONE
    } fetch_state_t;

    // Largest word count whose last data address still fits below 2^addr_w.
    function automatic int unsigned calc_maxn(input int unsigned addr_w, input int unsigned base);
        return (32'd1 << addr_w) - 32'd1 - base;
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO; head is visible combinationally, push and pop may coincide.
module skid_fifo2 #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            mem0   <= '0;
            mem1   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                if (wr_ptr) mem1 <= push_data;
                else        mem0 <= push_data;
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head  = rd_ptr ? mem1 : mem0;
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/input_stream_fetcher.sv
// Reads a length header and N words from a 1-cycle-latency SRAM and streams
// them out with backpressure. A word transfers when out_valid && out_ready.
module input_stream_fetcher
    import ece564_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output fetch_state_t      state
);

    localparam int unsigned       MAXN   = calc_maxn(ADDR_W, 32'(BASE_ADDR));
    localparam logic [ADDR_W-1:0] MAXN_V = ADDR_W'(MAXN);

    logic [ADDR_W-1:0] n_q;
    logic [ADDR_W-1:0] n_clamped;
    logic [ADDR_W-1:0] issued;
    logic [ADDR_W-1:0] delivered;
    logic              inflight;
    logic              inflight_last;
    logic              issue;
    logic              pop;
    logic              xfer_last;
    logic [1:0]        fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   head;

    always_comb begin
        n_clamped = sram_dut_read_data[ADDR_W-1:0];
        if (32'(sram_dut_read_data) > MAXN) n_clamped = MAXN_V;
    end

    assign pop       = !fifo_empty && out_ready;
    assign xfer_last = pop && (delivered == n_q - ADDR_W'(1));

    // Credit counts the slot freed by this cycle's pop, so a steady ready
    // sustains one word per cycle without ever overflowing the two entries.
    assign issue = (state == STREAM) && (issued != n_q) && !(fifo_full && !pop)
                && (({1'b0, fifo_count} - {2'b00, pop} + {2'b00, inflight}) < 3'd2);

    assign dut_sram_read_address = issue ? (BASE_ADDR + ADDR_W'(1) + issued) : BASE_ADDR;

    skid_fifo2 #(.W(DATA_W + 1)) fifo (
        .clk       (clk),
        .reset_b   (reset_b),
        .push      (inflight),
        .push_data ({inflight_last, sram_dut_read_data}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head[DATA_W-1:0];
    assign out_last  = head[DATA_W];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state         <= IDLE;
            dut_busy      <= 1'b0;
            n_q           <= '0;
            issued        <= '0;
            delivered     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (issued == n_q - ADDR_W'(1));
            if (issue) issued <= issued + ADDR_W'(1);
            if (pop)   delivered <= delivered + ADDR_W'(1);
            case (state)
                IDLE: begin
                    if (dut_run) begin
                        dut_busy  <= 1'b1;
                        issued    <= '0;
                        delivered <= '0;
                        state     <= HDR;
                    end
                end
                HDR: begin
                    n_q   <= n_clamped;
                    state <= (n_clamped == '0) ? DONE : STREAM;
                end
                STREAM: begin
                    if (xfer_last) begin
                        dut_busy <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    dut_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_stream_fetcher.sv
// Directed bench for input_stream_fetcher: one instance at base 0x000 and one
// at base 0xFF0 share a behavioural 1-cycle-latency SRAM.
module tb_input_stream_fetcher;
    import ece564_pkg::*;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_b = 1'b0;
    logic          run0 = 1'b0, ready0 = 1'b1, run1 = 1'b0, ready1 = 1'b1;
    logic          busy0, busy1, valid0, valid1, last0, last1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1, rdata0, rdata1;
    fetch_state_t  state0, state1;
    logic [DW-1:0] mem [4096];

    int n_pass = 0;
    int n_total = 0;

    // scoreboard and per-job observations
    logic [DW-1:0] exp_q[$];
    int            got_cnt, data_errs, last_errs, extra;
    int            busy_cycles, first_valid, last_xfer, stall_bad, max_out, rises, post_bad;
    bit            timeout;
    logic [AW-1:0] addr_min, addr_max;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdata0 <= mem[addr0];
        rdata1 <= mem[addr1];
    end

    input_stream_fetcher #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(12'h000)) dut0 (
        .clk(clk), .reset_b(reset_b), .dut_run(run0), .dut_busy(busy0),
        .dut_sram_read_address(addr0), .sram_dut_read_data(rdata0),
        .out_valid(valid0), .out_data(data0), .out_last(last0),
        .out_ready(ready0), .state(state0)
    );

    input_stream_fetcher #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(12'hFF0)) dut1 (
        .clk(clk), .reset_b(reset_b), .dut_run(run1), .dut_busy(busy1),
        .dut_sram_read_address(addr1), .sram_dut_read_data(rdata1),
        .out_valid(valid1), .out_data(data1), .out_last(last1),
        .out_ready(ready1), .state(state1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads header n at base and data word (val0 + i) at base+i, queuing expectations.
    task automatic load_job(input int base, input int n, input int val0, input int words);
        mem[base] = DW'(n);
        exp_q.delete();
        for (int i = 1; i <= words; i++) begin
            mem[base + i] = DW'(val0 + i);
            exp_q.push_back(DW'(val0 + i));
        end
    endtask

    // Raises run, holds it until busy is seen, and observes the job until busy
    // has been low for four cycles. mode 0: ready always 1; mode 1: 1,0,0,1,0,1...
    task automatic run_job(input bit sel, input int mode, input int budget);
        bit            pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bit            p_valid = 0, p_ready = 0, p_busy = 0, p_last = 0;
        logic [DW-1:0] p_data = '0;
        bit            s_valid, s_busy, s_last, rdy;
        logic [DW-1:0] s_data, e;
        logic [AW-1:0] s_addr;
        int            done_cyc = -1;
        got_cnt = 0; data_errs = 0; last_errs = 0; extra = 0;
        busy_cycles = 0; first_valid = -1; last_xfer = -1; stall_bad = 0;
        max_out = 0; rises = 0; post_bad = 0; timeout = 0;
        addr_min = '1; addr_max = '0;
        if (sel) run1 = 1'b1; else run0 = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            tick();
            rdy = (mode == 0) ? 1'b1 : pat[cyc % 6];
            if (sel) ready1 = rdy; else ready0 = rdy;
            #1;
            s_valid = sel ? valid1 : valid0;
            s_busy  = sel ? busy1  : busy0;
            s_last  = sel ? last1  : last0;
            s_data  = sel ? data1  : data0;
            s_addr  = sel ? addr1  : addr0;
            if (s_busy) begin
                run0 = 1'b0;
                run1 = 1'b0;
                busy_cycles++;
                if (s_addr < addr_min) addr_min = s_addr;
                if (s_addr > addr_max) addr_max = s_addr;
            end
            if (s_busy && !p_busy) rises++;
            if (p_busy && !s_busy && done_cyc < 0) done_cyc = cyc;
            else if (done_cyc >= 0 && (s_valid || s_busy)) post_bad++;
            if (p_valid && !p_ready && (!s_valid || s_data !== p_data || s_last !== p_last))
                stall_bad++;
            if (s_valid && first_valid < 0) first_valid = cyc;
            if (s_valid && rdy) begin
                got_cnt++;
                last_xfer = cyc;
                if (exp_q.size() == 0) extra++;
                else begin
                    e = exp_q.pop_front();
                    if (s_data !== e) data_errs++;
                    if (s_last !== (exp_q.size() == 0)) last_errs++;
                end
            end
            if (!sel && int'(dut0.fifo_count) + int'(dut0.inflight) > max_out)
                max_out = int'(dut0.fifo_count) + int'(dut0.inflight);
            p_valid = s_valid; p_ready = rdy; p_busy = s_busy; p_last = s_last; p_data = s_data;
            if (done_cyc >= 0 && cyc == done_cyc + 4) break;
        end
        if (done_cyc < 0) timeout = 1;
        run0 = 1'b0;
        run1 = 1'b0;
        ready0 = 1'b1;
        ready1 = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_total++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy0); else n_pass++;
        n_total++; if (valid0 !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid0); else n_pass++;
        n_total++; if (last0 !== 1'b0) $display("FAIL reset_last: got %b want 0", last0); else n_pass++;
        n_total++; if (data0 !== 16'h0000) $display("FAIL reset_data: got %h want 0000", data0); else n_pass++;
        n_total++; if (addr0 !== 12'h000) $display("FAIL reset_addr: got %h want 000", addr0); else n_pass++;
        n_total++; if (addr1 !== 12'hFF0) $display("FAIL reset_addr_base: got %h want ff0", addr1); else n_pass++;
        n_total++; if (state0 !== IDLE) $display("FAIL reset_state: got %0d want %0d", state0, IDLE); else n_pass++;
        tick();
        reset_b = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        load_job(0, 4, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            mem[i] = DW'(16'h0011 * i);
            exp_q.push_back(DW'(16'h0011 * i));
        end
        run_job(1'b0, 0, 40);
        n_total++; if (timeout) $display("FAIL basic_timeout: busy never fell"); else n_pass++;
        n_total++; if (got_cnt !== 4) $display("FAIL basic_count: got %0d want 4", got_cnt); else n_pass++;
        n_total++; if (data_errs + extra !== 0) $display("FAIL basic_data: %0d bad words want 0", data_errs + extra); else n_pass++;
        n_total++; if (last_errs !== 0) $display("FAIL basic_last: %0d bad flags want 0", last_errs); else n_pass++;
        n_total++; if (first_valid !== 3) $display("FAIL basic_latency: got %0d want 3", first_valid); else n_pass++;
        n_total++; if (last_xfer !== 6) $display("FAIL basic_consecutive: last at %0d want 6", last_xfer); else n_pass++;
        n_total++; if (busy_cycles !== 7) $display("FAIL basic_busy_cycles: got %0d want 7", busy_cycles); else n_pass++;
        n_total++; if (rises !== 1) $display("FAIL basic_accepts: got %0d want 1", rises); else n_pass++;
        n_total++; if (post_bad !== 0) $display("FAIL basic_after_done: got %0d want 0", post_bad); else n_pass++;
    endtask

    task automatic test_empty();
        load_job(0, 0, 0, 0);
        run_job(1'b0, 0, 20);
        n_total++; if (busy_cycles !== 2) $display("FAIL empty_busy_cycles: got %0d want 2", busy_cycles); else n_pass++;
        n_total++; if (first_valid !== -1) $display("FAIL empty_valid: first at %0d want none", first_valid); else n_pass++;
        n_total++; if (addr_max !== 12'h000) $display("FAIL empty_addr: got %h want 000", addr_max); else n_pass++;
        n_total++; if (post_bad !== 0) $display("FAIL empty_after_done: got %0d want 0", post_bad); else n_pass++;
    endtask

    task automatic test_backpressure();
        load_job(0, 6, 16'h0100, 6);
        run_job(1'b0, 1, 80);
        n_total++; if (got_cnt !== 6) $display("FAIL bp_count: got %0d want 6", got_cnt); else n_pass++;
        n_total++; if (data_errs + extra !== 0) $display("FAIL bp_data: %0d bad words want 0", data_errs + extra); else n_pass++;
        n_total++; if (last_errs !== 0) $display("FAIL bp_last: %0d bad flags want 0", last_errs); else n_pass++;
        n_total++; if (stall_bad !== 0) $display("FAIL bp_stable: %0d unstable stalls want 0", stall_bad); else n_pass++;
        n_total++; if (max_out > 2) $display("FAIL bp_outstanding: got %0d want <=2", max_out); else n_pass++;
    endtask

    task automatic test_clamp();
        load_job(12'hFF0, 16'hFFFF, 16'h5000, 15);
        run_job(1'b1, 0, 60);
        n_total++; if (got_cnt !== 15) $display("FAIL clamp_count: got %0d want 15", got_cnt); else n_pass++;
        n_total++; if (data_errs + extra !== 0) $display("FAIL clamp_data: %0d bad words want 0", data_errs + extra); else n_pass++;
        n_total++; if (last_errs !== 0) $display("FAIL clamp_last: %0d bad flags want 0", last_errs); else n_pass++;
        n_total++; if (busy_cycles !== 18) $display("FAIL clamp_busy_cycles: got %0d want 18", busy_cycles); else n_pass++;
        n_total++; if (addr_max !== 12'hFFF) $display("FAIL clamp_addr_max: got %h want fff", addr_max); else n_pass++;
        n_total++; if (addr_min !== 12'hFF0) $display("FAIL clamp_no_wrap: min %h want ff0", addr_min); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int xfers = 0;
        bit hit = 0;
        int leak = 0;
        load_job(0, 8, 16'h0200, 8);
        run0 = 1'b1;
        ready0 = 1'b1;
        for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
            tick();
            if (busy0) run0 = 1'b0;
            if (xfers == 3) hit = 1;
            else if (valid0) xfers++;
        end
        n_total++; if (!hit) $display("FAIL rst_reach3: delivered %0d want 3", xfers); else n_pass++;
        run0 = 1'b0;
        reset_b = 1'b0;
        #1;
        n_total++; if (busy0 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy0); else n_pass++;
        n_total++; if (valid0 !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid0); else n_pass++;
        n_total++; if (addr0 !== 12'h000) $display("FAIL rst_addr: got %h want 000", addr0); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (valid0 || busy0) leak++;
        end
        reset_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (valid0 || busy0) leak++;
        end
        n_total++; if (leak !== 0) $display("FAIL rst_quiet: got %0d active cycles want 0", leak); else n_pass++;
        load_job(0, 2, 16'h0300, 2);
        run_job(1'b0, 0, 30);
        n_total++; if (got_cnt !== 2) $display("FAIL rst_new_count: got %0d want 2", got_cnt); else n_pass++;
        n_total++; if (data_errs + extra !== 0) $display("FAIL rst_new_data: %0d bad words want 0", data_errs + extra); else n_pass++;
        n_total++; if (last_errs !== 0) $display("FAIL rst_new_last: %0d bad flags want 0", last_errs); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int sizes[2] = '{96, 144};
        for (int r = 0; r < 2; r++) begin
            load_job(0, sizes[r], (r + 1) * 16'h1000, sizes[r]);
            run_job(1'b0, 0, sizes[r] + 40);
            n_total++; if (got_cnt !== sizes[r]) $display("FAIL b2b_count%0d: got %0d want %0d", r, got_cnt, sizes[r]); else n_pass++;
            n_total++; if (data_errs + extra !== 0) $display("FAIL b2b_data%0d: %0d bad words want 0", r, data_errs + extra); else n_pass++;
            n_total++; if (last_errs !== 0) $display("FAIL b2b_last%0d: %0d bad flags want 0", r, last_errs); else n_pass++;
            n_total++; if (rises !== 1) $display("FAIL b2b_accepts%0d: got %0d want 1", r, rises); else n_pass++;
            n_total++; if (busy_cycles !== sizes[r] + 3) $display("FAIL b2b_busy%0d: got %0d want %0d", r, busy_cycles, sizes[r] + 3); else n_pass++;
            n_total++; if (post_bad !== 0) $display("FAIL b2b_retrigger%0d: got %0d want 0", r, post_bad); else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_empty();
        test_backpressure();
        test_clamp();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
